reg_read_arbiter: RTL

Arbitrates the register file's single pair of operand-query ports between two requesters: requester 0 is the primary decode slot and requester 1 is the secondary or auxiliary slot. It accepts held requests with a grant pulse and registers the winner's rs1/rs2 indices. It drives them to the register file one cycle later and returns the captured ready/value/RoB-position results on a shared, tagged response bus. It sits between the decoders and the register file and is flushed by rollback.

---
 rtl/reg_read_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/reg_read_arbiter.sv
// Two-requester arbiter for the register file's operand-query port pair.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module reg_read_arbiter #(
   parameter int REG_W  = 5,
   parameter int DATA_W = 32,
   parameter int ROB_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rdy,
   input  logic              rollback,
   input  logic              req_v0,
   input  logic              req_v1,
   input  logic [REG_W-1:0]  req_rs1_0,
   input  logic [REG_W-1:0]  req_rs2_0,
   input  logic [REG_W-1:0]  req_rs1_1,
   input  logic [REG_W-1:0]  req_rs2_1,
   output logic              gnt0,
   output logic              gnt1,
   output logic [REG_W-1:0]  rf_rs1,
   output logic [REG_W-1:0]  rf_rs2,
   input  logic              rf_rs1_rdy,
   input  logic              rf_rs2_rdy,
   input  logic [DATA_W-1:0] rf_val1,
   input  logic [DATA_W-1:0] rf_val2,
   input  logic [ROB_W-1:0]  rf_rob_pos1,
   input  logic [ROB_W-1:0]  rf_rob_pos2,
   output logic              rsp_v,
   output logic              rsp_id,
   output logic              rsp_rs1_rdy,
   output logic              rsp_rs2_rdy,
   output logic [DATA_W-1:0] rsp_val1,
   output logic [DATA_W-1:0] rsp_val2,
   output logic [ROB_W-1:0]  rsp_rob_pos1,
   output logic [ROB_W-1:0]  rsp_rob_pos2
);

   logic              r_sel_v, r_sel_id, r_last_gnt;
   logic [REG_W-1:0]  r_sel_rs1, r_sel_rs2;
   logic              r_rsp_v, r_rsp_id, r_rsp_rdy1, r_rsp_rdy2;
   logic [DATA_W-1:0] r_rsp_val1, r_rsp_val2;
   logic [ROB_W-1:0]  r_rsp_pos1, r_rsp_pos2;

   logic w_en, w_acc, w_win, w_tie_pick, w_x0_1, w_x0_2;

`ifdef ARB_RR_EN
   assign w_tie_pick = ~r_last_gnt;
`else
   // last_gnt is kept up to date but never steers a fixed-priority tie
   assign w_tie_pick = r_last_gnt & 1'b0;
`endif

   assign w_en  = rst_n & rdy & ~rollback;
   assign w_win = (req_v0 & req_v1) ? w_tie_pick : req_v1;
   assign w_acc = w_en & (req_v0 | req_v1);
   assign gnt0  = w_acc & ~w_win;
   assign gnt1  = w_acc & w_win;

   assign rf_rs1 = r_sel_v ? r_sel_rs1 : '0;
   assign rf_rs2 = r_sel_v ? r_sel_rs2 : '0;
   assign w_x0_1 = (rf_rs1 == '0);
   assign w_x0_2 = (rf_rs2 == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel_v    <= 1'b0;
         r_sel_id   <= 1'b0;
         r_sel_rs1  <= '0;
         r_sel_rs2  <= '0;
         r_last_gnt <= 1'b1;
         r_rsp_v    <= 1'b0;
         r_rsp_id   <= 1'b0;
         r_rsp_rdy1 <= 1'b0;
         r_rsp_rdy2 <= 1'b0;
         r_rsp_val1 <= '0;
         r_rsp_val2 <= '0;
         r_rsp_pos1 <= '0;
         r_rsp_pos2 <= '0;
      end else if (rollback) begin
         // in-flight requests are dropped; rollback wins over a stalled rdy
         r_sel_v    <= 1'b0;
         r_rsp_v    <= 1'b0;
         r_last_gnt <= 1'b1;
      end else if (rdy) begin
         r_sel_v <= w_acc;
         if (w_acc) begin
            r_sel_id   <= w_win;
            r_sel_rs1  <= w_win ? req_rs1_1 : req_rs1_0;
            r_sel_rs2  <= w_win ? req_rs2_1 : req_rs2_0;
            r_last_gnt <= w_win;
         end
         r_rsp_v    <= r_sel_v;
         r_rsp_id   <= r_sel_id;
         r_rsp_rdy1 <= w_x0_1 | rf_rs1_rdy;
         r_rsp_rdy2 <= w_x0_2 | rf_rs2_rdy;
         r_rsp_val1 <= w_x0_1 ? '0 : rf_val1;
         r_rsp_val2 <= w_x0_2 ? '0 : rf_val2;
         r_rsp_pos1 <= w_x0_1 ? '0 : rf_rob_pos1;
         r_rsp_pos2 <= w_x0_2 ? '0 : rf_rob_pos2;
      end
   end

   assign rsp_v        = r_rsp_v;
   assign rsp_id       = r_rsp_id;
   assign rsp_rs1_rdy  = r_rsp_rdy1;
   assign rsp_rs2_rdy  = r_rsp_rdy2;
   assign rsp_val1     = r_rsp_val1;
   assign rsp_val2     = r_rsp_val2;
   assign rsp_rob_pos1 = r_rsp_pos1;
   assign rsp_rob_pos2 = r_rsp_pos2;

endmodule
